pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_skid_stage.sv | 99 +++++++++
 tb/tb_pipe_skid_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - two-entry in-order skid buffer pipeline stage
module pipe_skid_stage #(
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 2,
  parameter int RD_W     = 5,
  parameter int CTRL_W   = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_DATA*DATA_W-1:0] data_in,
  input  logic [RD_W-1:0]            rd_in,
  input  logic [CTRL_W-1:0]          ctrl_in,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_DATA*DATA_W-1:0] data_out,
  output logic [RD_W-1:0]            rd_out,
  output logic [CTRL_W-1:0]          ctrl_out,
  output logic [1:0]                 occupancy
);

  localparam int PW = NUM_DATA * DATA_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [PW-1:0]     main_data, skid_data;
  logic [RD_W-1:0]   main_rd, skid_rd;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              accept, pop;

  // in_ready never looks at out_ready, so there is no combinational path
  // from downstream back upstream.
  assign in_ready  = (state != FULL) && reset && !flush;
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign occupancy = state;

  assign data_out = main_data;
  assign rd_out   = main_rd;
  // A bubble must never look like a write to memory or the register file.
  assign ctrl_out = out_valid ? main_ctrl : '0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= EMPTY;
      main_data <= '0;
      main_rd   <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_rd   <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_data <= data_in;
            main_rd   <= rd_in;
            main_ctrl <= ctrl_in;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_data <= data_in;
            main_rd   <= rd_in;
            main_ctrl <= ctrl_in;
          end else if (accept) begin
            skid_data <= data_in;
            skid_rd   <= rd_in;
            skid_ctrl <= ctrl_in;
            state     <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_data <= skid_data;
            main_rd   <= skid_rd;
            main_ctrl <= skid_ctrl;
            state     <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - scoreboard bench for pipe_skid_stage
module tb_pipe_skid_stage;

  localparam int DATA_W   = 16;
  localparam int NUM_DATA = 4;
  localparam int RD_W     = 5;
  localparam int CTRL_W   = 3;
  localparam int PW       = DATA_W * NUM_DATA;

  typedef struct packed {
    logic [PW-1:0]     d;
    logic [RD_W-1:0]   rd;
    logic [CTRL_W-1:0] c;
  } beat_t;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PW-1:0]     data_in = '0;
  logic [RD_W-1:0]   rd_in = '0;
  logic [CTRL_W-1:0] ctrl_in = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [PW-1:0]     data_out;
  logic [RD_W-1:0]   rd_out;
  logic [CTRL_W-1:0] ctrl_out;
  logic [1:0]        occupancy;

  int    n_tests = 0;
  int    n_fail  = 0;
  bit    mon_on  = 1'b0;
  beat_t q[$];
  beat_t last_shown = '0;

  pipe_skid_stage #(
    .DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .RD_W(RD_W), .CTRL_W(CTRL_W)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .rd_in(rd_in), .ctrl_in(ctrl_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .rd_out(rd_out), .ctrl_out(ctrl_out), .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of at most two beats, observed at the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      if (mon_on) begin
        int  sz;
        bit  acc;
        sz = q.size();
        check("out_valid", PW'(out_valid), PW'(sz != 0));
        check("occupancy", PW'(occupancy), PW'(sz));
        check("in_ready", PW'(in_ready), PW'(reset && !flush && sz < 2));
        if (sz != 0) begin
          check("data_out", data_out, q[0].d);
          check("rd_out", PW'(rd_out), PW'(q[0].rd));
          check("ctrl_out", PW'(ctrl_out), PW'(q[0].c));
          last_shown = q[0];
        end else begin
          check("data_hold", data_out, last_shown.d);
          check("rd_hold", PW'(rd_out), PW'(last_shown.rd));
          check("ctrl_bubble", PW'(ctrl_out), '0);
        end
        acc = in_valid && sz < 2;
        if (!reset) begin
          q.delete();
          last_shown = '0;
        end else if (flush) begin
          q.delete();
        end else begin
          if (sz != 0 && out_ready) void'(q.pop_front());
          if (acc) q.push_back('{d: data_in, rd: rd_in, c: ctrl_in});
        end
      end
    end
  end

  task automatic cyc(input bit v, input logic [PW-1:0] d, input logic [RD_W-1:0] r,
                     input logic [CTRL_W-1:0] c, input bit ordy, input bit fl, input bit rst);
    in_valid  = v;
    data_in   = d;
    rd_in     = r;
    ctrl_in   = c;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    @(posedge clock);
    #1;
  endtask

  logic [PW-1:0] a_val, b_val, c_val;

  initial begin
    a_val = {16'h0011, 16'h0022, 16'h0033, 16'h0044};
    b_val = {16'hb0b0, 16'hb1b1, 16'hb2b2, 16'hb3b3};
    c_val = {16'hc0c0, 16'hc1c1, 16'hc2c2, 16'hc3c3};
    @(posedge clock);
    #1;
    mon_on = 1'b1;
    cyc(1, a_val, 5'd9, 3'b111, 1, 0, 0);
    cyc(0, '0, '0, '0, 1, 0, 0);

    // Pass-through with one cycle latency.
    cyc(1, a_val, 5'd3, 3'b101, 1, 0, 1);
    check("pt_data", data_out, a_val);
    check("pt_ctrl", PW'(ctrl_out), PW'(3'b101));
    check("pt_occ", PW'(occupancy), PW'(1));
    cyc(0, '0, '0, '0, 1, 0, 1);
    cyc(0, '0, '0, '0, 1, 0, 1);

    // Backpressure fills both entries, then drains in order.
    cyc(1, a_val, 5'd1, 3'b001, 0, 0, 1);
    cyc(1, b_val, 5'd2, 3'b010, 0, 0, 1);
    check("bp_occ", PW'(occupancy), PW'(2));
    check("bp_in_ready", PW'(in_ready), '0);
    check("bp_data", data_out, a_val);
    for (int i = 0; i < 3; i++) cyc(0, '0, '0, '0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, '0, '0, '0, 1, 0, 1);

    // Back-to-back streaming.
    for (int i = 0; i < 8; i++) cyc(1, PW'(i), RD_W'(i), CTRL_W'(i), 1, 0, 1);
    cyc(0, '0, '0, '0, 1, 0, 1);
    cyc(0, '0, '0, '0, 1, 0, 1);

    // Flush in FULL with a coincident incoming beat.
    cyc(1, a_val, 5'd4, 3'b100, 0, 0, 1);
    cyc(1, b_val, 5'd5, 3'b011, 0, 0, 1);
    cyc(1, c_val, 5'd6, 3'b111, 0, 1, 1);
    check("fl_occ", PW'(occupancy), '0);
    check("fl_ctrl", PW'(ctrl_out), '0);
    for (int i = 0; i < 3; i++) cyc(0, '0, '0, '0, 1, 0, 1);

    // Reset in FULL.
    cyc(1, a_val, 5'd7, 3'b110, 0, 0, 1);
    cyc(1, b_val, 5'd8, 3'b101, 0, 0, 1);
    cyc(1, c_val, 5'd9, 3'b111, 1, 0, 0);
    check("rst_data", data_out, '0);
    check("rst_in_ready", PW'(in_ready), '0);
    cyc(1, c_val, 5'd9, 3'b111, 1, 0, 0);
    cyc(0, '0, '0, '0, 1, 0, 1);
    check("rel_in_ready", PW'(in_ready), PW'(1));

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 10000; i++) begin
      cyc(($urandom % 4) != 0, {$urandom, $urandom}, RD_W'($urandom), CTRL_W'($urandom),
          ($urandom % 3) != 0, ($urandom % 64) == 0, ($urandom % 256) != 0);
    end
    for (int i = 0; i < 3; i++) cyc(0, '0, '0, '0, 1, 0, 1);
    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
